// File: rtl/sha1_round_stage_if.sv
// ---------------------------------------------------------------------------
// sha1_round_stage_if
// Purpose : Bundles the control/data signals between the SHA-1 controller
//           and one registered round stage.
// Signals : load      - load cv_in into the working-state register
//           cv_in     - 160-bit initial state {A,B,C,D,E}, A in [159:128]
//           step      - perform one round on the working state
//           w         - 32-bit message schedule word W_t
//           round     - 7-bit round index t (0..79)
//           rnd_out   - registered working state {A,B,C,D,E}
//           rnd_next  - combinational next state f(rnd_out, w, round)
//           range_err - sticky out-of-range round flag
//                       (only when SHA1_ROUND_RANGE_CHECK_EN is defined)
// Modports: master = controller side, slave = round stage side.
// ---------------------------------------------------------------------------
interface sha1_round_stage_if;
   logic         load;
   logic [159:0] cv_in;
   logic         step;
   logic [31:0]  w;
   logic [6:0]   round;
   logic [159:0] rnd_out;
   logic [159:0] rnd_next;
`ifdef SHA1_ROUND_RANGE_CHECK_EN
   logic         range_err;

   modport master (output load, cv_in, step, w, round,
                   input  rnd_out, rnd_next, range_err);
   modport slave  (input  load, cv_in, step, w, round,
                   output rnd_out, rnd_next, range_err);
`else
   modport master (output load, cv_in, step, w, round,
                   input  rnd_out, rnd_next);
   modport slave  (input  load, cv_in, step, w, round,
                   output rnd_out, rnd_next);
`endif
endinterface

// File: rtl/sha1_round_stage.sv
// ---------------------------------------------------------------------------
// sha1_round_stage
// Purpose : Registered single-round SHA-1 compression unit. Holds the
//           160-bit working state {A,B,C,D,E} and advances it by one SHA-1
//           round per clock in which step is asserted. Chaining-value load
//           and the final feed-forward add are done by the controller.
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-low clear of the state
//           bus   - sha1_round_stage_if.slave
//                   (load, cv_in, step, w, round -> rnd_out, rnd_next)
// Priority at the clock edge: reset > load > step > hold.
// Option  : SHA1_ROUND_RANGE_CHECK_EN adds the registered range_err flag,
//           set when a round with index > 79 is stepped, cleared by reset
//           or load. Out-of-range rounds always compute as the 60-79 group.
// ---------------------------------------------------------------------------
module sha1_round_stage (
   input  logic              clk,
   input  logic              reset,
   sha1_round_stage_if.slave bus
);

   logic [159:0] r_state;
   logic [31:0]  w_a, w_b, w_c, w_d, w_e;
   logic [31:0]  w_f, w_k, w_t;
   logic [159:0] w_next;

   assign {w_a, w_b, w_c, w_d, w_e} = r_state;

   // Round-group selection of the boolean function and constant. The final
   // else covers both 60-79 and any index >= 80.
   always_comb begin
      // NOTE: defaults are assigned first so every path drives both
      // outputs and no latch is inferred.
      w_f = w_b ^ w_c ^ w_d;
      w_k = 32'hCA62C1D6;
      if (bus.round < 7'd20) begin
         w_f = (w_b & w_c) | (~w_b & w_d);
         w_k = 32'h5A827999;
      end else if (bus.round < 7'd40) begin
         w_f = w_b ^ w_c ^ w_d;
         w_k = 32'h6ED9EBA1;
      end else if (bus.round < 7'd60) begin
         w_f = (w_b & w_c) | (w_b & w_d) | (w_c & w_d);
         w_k = 32'h8F1BBCDC;
      end
   end

   // T = ROTL5(A) + F + E + K + W, all modulo 2^32.
   assign w_t    = {w_a[26:0], w_a[31:27]} + w_f + w_e + w_k + bus.w;
   assign w_next = {w_t, w_a, {w_b[1:0], w_b[31:2]}, w_c, w_d};

   // Enable is a mux in front of D; the clear is synchronous.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // flops sample the pre-edge values regardless of statement order.
      if (!reset) begin
         r_state <= 160'h0;
      end else if (bus.load) begin
         r_state <= bus.cv_in;
      end else if (bus.step) begin
         r_state <= w_next;
      end
   end

   assign bus.rnd_out  = r_state;
   assign bus.rnd_next = w_next;

`ifdef SHA1_ROUND_RANGE_CHECK_EN
   logic r_range_err;

   // Sticky until the controller reloads; a stepped index > 79 is flagged
   // but still processed as the 60-79 group.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_range_err <= 1'b0;
      end else if (bus.load) begin
         r_range_err <= 1'b0;
      end else if (bus.step && (bus.round > 7'd79)) begin
         r_range_err <= 1'b1;
      end
   end

   assign bus.range_err = r_range_err;
`endif

endmodule

// File: tb/tb_sha1_round_stage.sv
// ---------------------------------------------------------------------------
// tb_sha1_round_stage
// Purpose : Self-checking bench for sha1_round_stage. An independent SHA-1
//           round model computes the expected state for every driven cycle;
//           expectations are queued when inputs are applied and popped when
//           the registered result is sampled. Published SHA-1 "abc" vectors
//           are checked as literal constants.
// Option  : define SHA1_ROUND_RANGE_CHECK_EN to also check range_err.
// ---------------------------------------------------------------------------
module tb_sha1_round_stage;

   logic clk = 1'b0;
   logic reset;

   sha1_round_stage_if bus ();

   sha1_round_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [159:0] sb_q[$];
   logic [159:0] m_state;
   logic [31:0]  w_sched [80];

   localparam logic [159:0] IV =
      160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Reference SHA-1 round, written from the textbook definition.
   function automatic logic [159:0] ref_round(input logic [159:0] s,
                                              input logic [31:0] wt,
                                              input int t);
      logic [31:0] a, b, c, d, e, f, k, tmp;
      a = s[159:128]; b = s[127:96]; c = s[95:64]; d = s[63:32]; e = s[31:0];
      case (t / 20)
         0:       begin f = (b & c) | ((~b) & d);         k = 32'h5A827999; end
         1:       begin f = b ^ c ^ d;                    k = 32'h6ED9EBA1; end
         2:       begin f = (b & c) | (b & d) | (c & d);  k = 32'h8F1BBCDC; end
         default: begin f = b ^ c ^ d;                    k = 32'hCA62C1D6; end
      endcase
      tmp = rotl(a, 5) + f + e + k + wt;
      return {tmp, a, rotl(b, 30), c, d};
   endfunction

   task automatic check(input string tag, input logic [159:0] obs,
                        input logic [159:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, queue the modelled result, sample after the
   // edge and compare against the popped expectation.
   task automatic cycle(input string tag, input logic rs, input logic ld,
                        input logic [159:0] cv, input logic st,
                        input logic [31:0] ww, input int rr);
      logic [159:0] exp;
      @(negedge clk);
      reset     = rs;
      bus.load  = ld;
      bus.cv_in = cv;
      bus.step  = st;
      bus.w     = ww;
      bus.round = rr[6:0];
      if (!rs)      exp = 160'h0;
      else if (ld)  exp = cv;
      else if (st)  exp = ref_round(m_state, ww, rr);
      else          exp = m_state;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      check(tag, bus.rnd_out, exp);
      m_state = exp;
   endtask

   initial begin
      logic [159:0] kgrp [4];
      logic [159:0] held;
      logic [159:0] dig;
      int           grp_t [4];

      reset     = 1'b1;
      bus.load  = 1'b0;
      bus.cv_in = '0;
      bus.step  = 1'b0;
      bus.w     = '0;
      bus.round = '0;
      m_state   = '0;

      kgrp[0] = {32'h5A827999, 128'h0};
      kgrp[1] = {32'h6ED9EBA1, 128'h0};
      kgrp[2] = {32'h8F1BBCDC, 128'h0};
      kgrp[3] = {32'hCA62C1D6, 128'h0};
      grp_t[0] = 0; grp_t[1] = 20; grp_t[2] = 40; grp_t[3] = 60;

      w_sched[0] = 32'h61626380;
      for (int i = 1; i < 15; i++) w_sched[i] = 32'h0;
      w_sched[15] = 32'h00000018;
      for (int i = 16; i < 80; i++)
         w_sched[i] = rotl(w_sched[i-3] ^ w_sched[i-8] ^ w_sched[i-14] ^ w_sched[i-16], 1);

      // Reset overrides a simultaneous load.
      cycle("reset_over_load", 1'b0, 1'b1, {160{1'b1}}, 1'b0, 32'h0, 0);
`ifdef SHA1_ROUND_RANGE_CHECK_EN
      check("range_err_reset", {159'h0, bus.range_err}, 160'h0);
`endif

      // Zero state, w=0, one round from each group gives {K,0,0,0,0}.
      for (int g = 0; g < 4; g++) begin
         cycle("zero_load", 1'b1, 1'b1, 160'h0, 1'b0, 32'h0, 0);
         cycle("zero_step", 1'b1, 1'b0, 160'h0, 1'b1, 32'h0, grp_t[g]);
         check("zero_group_const", bus.rnd_out, kgrp[g]);
      end

      // "abc" round 0, combinational output first, then the registered one.
      cycle("abc_load", 1'b1, 1'b1, IV, 1'b0, 32'h0, 0);
      @(negedge clk);
      bus.w     = 32'h61626380;
      bus.round = 7'd0;
      #1;
      check("abc_r0_next", bus.rnd_next,
            160'h0116FC33_67452301_7BF36AE2_98BADCFE_10325476);
      cycle("abc_r0_step", 1'b1, 1'b0, IV, 1'b1, 32'h61626380, 0);
      check("abc_r0_const", bus.rnd_out,
            160'h0116FC33_67452301_7BF36AE2_98BADCFE_10325476);

      // Full "abc" block: 80 rounds then feed-forward add.
      cycle("blk_load", 1'b1, 1'b1, IV, 1'b0, 32'h0, 0);
      for (int t = 0; t < 80; t++)
         cycle("blk_step", 1'b1, 1'b0, 160'h0, 1'b1, w_sched[t], t);
      check("blk_final", bus.rnd_out,
            160'h42541B35_5738D5E1_21834873_681E6DF6_D8FDF6AD);
      dig = bus.rnd_out;
      for (int i = 0; i < 5; i++)
         dig[32*i +: 32] = dig[32*i +: 32] + IV[32*i +: 32];
      check("blk_digest", dig,
            160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);

      // load and step together: load wins, no round computed.
      cycle("load_over_step", 1'b1, 1'b1, IV, 1'b1, 32'hDEADBEEF, 5);
      check("load_over_step_cv", bus.rnd_out, IV);

      // Rounds 0..40, then three idle cycles must hold, then reset clears.
      for (int t = 0; t <= 40; t++)
         cycle("mid_step", 1'b1, 1'b0, 160'h0, 1'b1, w_sched[t], t);
      held = bus.rnd_out;
      for (int i = 0; i < 3; i++) begin
         cycle("hold", 1'b1, 1'b0, 160'h0, 1'b0, 32'h12345678, 7);
         check("hold_value", bus.rnd_out, held);
      end
      cycle("mid_reset", 1'b0, 1'b0, 160'h0, 1'b1, 32'h0, 41);
      check("mid_reset_zero", bus.rnd_out, 160'h0);

      // Out-of-range rounds compute as the 60-79 group.
      cycle("oor_load0", 1'b1, 1'b1, 160'h0, 1'b0, 32'h0, 0);
      cycle("oor_r80_zero", 1'b1, 1'b0, 160'h0, 1'b1, 32'h0, 80);
      check("oor_r80_const", bus.rnd_out, kgrp[3]);
      cycle("oor_load_iv", 1'b1, 1'b1, IV, 1'b0, 32'h0, 0);
      cycle("oor_r79", 1'b1, 1'b0, 160'h0, 1'b1, 32'hA5A5A5A5, 79);
`ifdef SHA1_ROUND_RANGE_CHECK_EN
      check("range_err_r79", {159'h0, bus.range_err}, 160'h0);
`endif
      cycle("oor_r127", 1'b1, 1'b0, 160'h0, 1'b1, 32'h0F0F0F0F, 127);
`ifdef SHA1_ROUND_RANGE_CHECK_EN
      check("range_err_set", {159'h0, bus.range_err}, 160'h1);
      cycle("range_hold", 1'b1, 1'b0, 160'h0, 1'b0, 32'h0, 0);
      check("range_err_sticky", {159'h0, bus.range_err}, 160'h1);
      cycle("range_load", 1'b1, 1'b1, IV, 1'b0, 32'h0, 0);
      check("range_err_clear", {159'h0, bus.range_err}, 160'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
